// File: rtl/pix_pattern_gen.sv
// Camera-style pixel pattern source: FV/LV/data timing generator with four test patterns.
// Frame geometry is captured at frame start, so input changes only affect the next frame.
module pix_pattern_gen #(
  parameter int FV_LEAD_CYC  = 8,
  parameter int FV_TRAIL_CYC = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [1:0]  mode,
  input  logic [11:0] h_active,
  input  logic [11:0] h_blank,
  input  logic [11:0] v_active,
  input  logic [15:0] v_blank,
  output logic        pix_fv,
  output logic        pix_lv,
  output logic [11:0] pix_data,
  output logic [15:0] frame_count,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FV_LEAD  = 3'd1,
    S_LINE     = 3'd2,
    S_HBLANK   = 3'd3,
    S_FV_TRAIL = 3'd4,
    S_VBLANK   = 3'd5
  } state_t;

  localparam logic [15:0] LEAD_LOAD  = 16'(FV_LEAD_CYC - 1);
  localparam logic [15:0] TRAIL_LOAD = 16'(FV_TRAIL_CYC - 1);

  state_t      state_r;
  logic [15:0] cnt_r;
  logic [11:0] col_r;
  logic [11:0] row_r;
  logic [1:0]  mode_r;
  logic [11:0] h_act_r;
  logic [11:0] h_blank_r;
  logic [11:0] v_act_r;
  logic [15:0] v_blank_r;
  logic        fv_r;
  logic        lv_r;
  logic [11:0] data_r;
  logic [15:0] frame_cnt_r;
  logic        busy_r;

  logic        start_frame_s;
  logic        cnt_done_s;
  logic        last_line_s;

  function automatic logic [11:0] pattern_f(input logic [1:0]  m,
                                            input logic [11:0] c,
                                            input logic [11:0] r,
                                            input logic [15:0] fc);
    logic [11:0] p;
    case (m)
      2'd0:    p = c;
      2'd1:    p = r;
      2'd2:    p = (c[3] ^ r[3]) ? 12'hFFF : 12'h000;
      2'd3:    p = {fc[3:0], c[7:0]};
      default: p = 12'h000;
    endcase
    return p;
  endfunction

  // Frame-start and end-of-state decode from the current registered state.
  always_comb begin
    start_frame_s = 1'b0;
    cnt_done_s    = (cnt_r == 16'd0);
    last_line_s   = (row_r == (v_act_r - 12'd1));
    case (state_r)
      S_IDLE:   start_frame_s = enable;
      S_VBLANK: start_frame_s = cnt_done_s & enable;
      default:  start_frame_s = 1'b0;
    endcase
  end

  // Timing FSM with counters and registered video outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= S_IDLE;
      cnt_r       <= 16'd0;
      col_r       <= 12'd0;
      row_r       <= 12'd0;
      mode_r      <= 2'd0;
      h_act_r     <= 12'd1;
      h_blank_r   <= 12'd1;
      v_act_r     <= 12'd1;
      v_blank_r   <= 16'd0;
      fv_r        <= 1'b0;
      lv_r        <= 1'b0;
      data_r      <= 12'd0;
      frame_cnt_r <= 16'd0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          fv_r   <= 1'b0;
          lv_r   <= 1'b0;
          data_r <= 12'd0;
          busy_r <= 1'b0;
        end
        S_FV_LEAD: begin
          if (cnt_done_s) begin
            state_r <= S_LINE;
            lv_r    <= 1'b1;
            col_r   <= 12'd0;
            data_r  <= pattern_f(mode_r, 12'd0, row_r, frame_cnt_r);
            cnt_r   <= {4'd0, h_act_r - 12'd1};
          end else begin
            cnt_r <= cnt_r - 16'd1;
          end
        end
        S_LINE: begin
          if (cnt_done_s) begin
            lv_r   <= 1'b0;
            data_r <= 12'd0;
            row_r  <= row_r + 12'd1;
            if (last_line_s) begin
              state_r <= S_FV_TRAIL;
              cnt_r   <= TRAIL_LOAD;
            end else begin
              state_r <= S_HBLANK;
              cnt_r   <= {4'd0, h_blank_r - 12'd1};
            end
          end else begin
            col_r  <= col_r + 12'd1;
            data_r <= pattern_f(mode_r, col_r + 12'd1, row_r, frame_cnt_r);
            cnt_r  <= cnt_r - 16'd1;
          end
        end
        S_HBLANK: begin
          if (cnt_done_s) begin
            state_r <= S_LINE;
            lv_r    <= 1'b1;
            col_r   <= 12'd0;
            data_r  <= pattern_f(mode_r, 12'd0, row_r, frame_cnt_r);
            cnt_r   <= {4'd0, h_act_r - 12'd1};
          end else begin
            cnt_r <= cnt_r - 16'd1;
          end
        end
        S_FV_TRAIL: begin
          if (cnt_done_s) begin
            fv_r        <= 1'b0;
            frame_cnt_r <= frame_cnt_r + 16'd1;
            // Zero blanking skips S_VBLANK; S_IDLE then makes the run/stop decision.
            if (v_blank_r == 16'd0) begin
              state_r <= S_IDLE;
              busy_r  <= 1'b0;
            end else begin
              state_r <= S_VBLANK;
              cnt_r   <= v_blank_r - 16'd1;
            end
          end else begin
            cnt_r <= cnt_r - 16'd1;
          end
        end
        S_VBLANK: begin
          if (cnt_done_s) begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
          end else begin
            cnt_r <= cnt_r - 16'd1;
          end
        end
        default: begin
          state_r <= S_IDLE;
          fv_r    <= 1'b0;
          lv_r    <= 1'b0;
          data_r  <= 12'd0;
          busy_r  <= 1'b0;
        end
      endcase

      if (start_frame_s) begin
        state_r   <= S_FV_LEAD;
        fv_r      <= 1'b1;
        lv_r      <= 1'b0;
        data_r    <= 12'd0;
        busy_r    <= 1'b1;
        cnt_r     <= LEAD_LOAD;
        col_r     <= 12'd0;
        row_r     <= 12'd0;
        mode_r    <= mode;
        h_act_r   <= (h_active == 12'd0) ? 12'd1 : h_active;
        h_blank_r <= (h_blank == 12'd0) ? 12'd1 : h_blank;
        v_act_r   <= (v_active == 12'd0) ? 12'd1 : v_active;
        v_blank_r <= v_blank;
      end
    end
  end

  assign pix_fv      = fv_r;
  assign pix_lv      = lv_r;
  assign pix_data    = data_r;
  assign frame_count = frame_cnt_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_pix_pattern_gen.sv
// Scoreboard bench for pix_pattern_gen: expected pixels are queued from a reference
// pattern model at stimulus time; a negedge monitor collects pixels and FV/LV timing.
module tb_pix_pattern_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [1:0]  mode;
  logic [11:0] h_active;
  logic [11:0] h_blank;
  logic [11:0] v_active;
  logic [15:0] v_blank;
  logic        pix_fv;
  logic        pix_lv;
  logic [11:0] pix_data;
  logic [15:0] frame_count;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  logic [11:0] exp_pix[$];
  logic [11:0] obs_pix[$];
  int          obs_hi[$];
  int          obs_lo[$];
  int          obs_burst[$];
  int          obs_gap[$];
  int          obs_lead[$];
  int          obs_trail[$];
  int          proto_viol = 0;
  logic [15:0] exp_fc;

  logic fv_p, lv_p, seen_lv;
  int   hi_n, lo_n, burst_n, gap_n;

  pix_pattern_gen #(.FV_LEAD_CYC(8), .FV_TRAIL_CYC(8)) dut (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode),
    .h_active(h_active), .h_blank(h_blank), .v_active(v_active), .v_blank(v_blank),
    .pix_fv(pix_fv), .pix_lv(pix_lv), .pix_data(pix_data),
    .frame_count(frame_count), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference pattern written arithmetically rather than bitwise.
  function automatic logic [11:0] exp_pat(input int m, input int c, input int r, input int fc);
    int v;
    case (m)
      0:       v = c;
      1:       v = r;
      2:       v = (((c / 8) % 2) != ((r / 8) % 2)) ? 4095 : 0;
      default: v = (fc % 16) * 256 + (c % 256);
    endcase
    return 12'(v);
  endfunction

  task automatic push_frame(input int m, input int ha, input int va, input int fc);
    int eh, ev;
    eh = (ha == 0) ? 1 : ha;
    ev = (va == 0) ? 1 : va;
    for (int r = 0; r < ev; r++)
      for (int c = 0; c < eh; c++)
        exp_pix.push_back(exp_pat(m, c, r, fc));
  endtask

  task automatic set_cfg(input logic [1:0] m, input logic [11:0] ha, input logic [11:0] hb,
                         input logic [11:0] va, input logic [15:0] vb);
    mode = m; h_active = ha; h_blank = hb; v_active = va; v_blank = vb;
  endtask

  task automatic clear_obs();
    exp_pix.delete(); obs_pix.delete(); obs_hi.delete(); obs_lo.delete();
    obs_burst.delete(); obs_gap.delete(); obs_lead.delete(); obs_trail.delete();
  endtask

  task automatic wait_fv_rises(input int n, input int bound, output bit ok);
    int   rises;
    logic prev;
    rises = 0; prev = pix_fv; ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (pix_fv && !prev) rises++;
      prev = pix_fv;
      if (rises >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_idle(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
    @(negedge clk);
    #1;
  endtask

  // Monitor: pixel capture plus FV/LV high, low, lead, gap and trail lengths.
  initial begin
    fv_p = 1'b0; lv_p = 1'b0; seen_lv = 1'b0;
    hi_n = 0; lo_n = 0; burst_n = 0; gap_n = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        fv_p = 1'b0; lv_p = 1'b0; seen_lv = 1'b0;
        hi_n = 0; lo_n = 0; burst_n = 0; gap_n = 0;
      end else begin
        if (pix_lv) obs_pix.push_back(pix_data);
        else if (pix_data !== 12'd0) proto_viol++;
        if (pix_lv && !pix_fv) proto_viol++;
        if (pix_fv && !fv_p) begin
          obs_lo.push_back(lo_n); hi_n = 0; gap_n = 0; seen_lv = 1'b0;
        end
        if (!pix_fv && fv_p) begin
          obs_hi.push_back(hi_n); obs_trail.push_back(gap_n); lo_n = 0;
        end
        if (pix_lv && !lv_p) begin
          if (seen_lv) obs_gap.push_back(gap_n);
          else obs_lead.push_back(gap_n);
          burst_n = 0;
        end
        if (!pix_lv && lv_p) begin
          obs_burst.push_back(burst_n); seen_lv = 1'b1; gap_n = 0;
        end
        if (pix_fv) hi_n++; else lo_n++;
        if (pix_lv) burst_n++;
        if (pix_fv && !pix_lv) gap_n++;
        fv_p = pix_fv; lv_p = pix_lv;
      end
    end
  end

  task automatic test_reset();
    int fv_seen;
    reset = 1'b1; enable = 1'b0;
    set_cfg(2'd0, 12'd8, 12'd4, 12'd3, 16'd10);
    repeat (3) @(negedge clk);
    checks++; if (pix_fv !== 1'b0) begin failures++; $display("FAIL reset_fv: got %b want 0", pix_fv); end
    checks++; if (pix_lv !== 1'b0) begin failures++; $display("FAIL reset_lv: got %b want 0", pix_lv); end
    checks++; if (pix_data !== 12'd0) begin failures++; $display("FAIL reset_data: got %h want 000", pix_data); end
    checks++; if (frame_count !== 16'd0) begin failures++; $display("FAIL reset_fc: got %h want 0000", frame_count); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    reset = 1'b0;
    fv_seen = 0;
    repeat (20) begin @(negedge clk); if (pix_fv !== 1'b0 || busy !== 1'b0) fv_seen++; end
    checks++; if (fv_seen != 0) begin failures++; $display("FAIL idle_no_start: active cycles %0d want 0", fv_seen); end
    exp_fc = 16'd0;
  endtask

  task automatic test_single_frame();
    bit ok;
    int viol0, fv_seen;
    logic [11:0] e, o;
    clear_obs();
    viol0 = proto_viol;
    set_cfg(2'd0, 12'd8, 12'd4, 12'd3, 16'd10);
    push_frame(0, 8, 3, int'(exp_fc));
    @(negedge clk); enable = 1'b1;
    @(negedge clk); enable = 1'b0;
    checks++; if (pix_fv !== 1'b1) begin failures++; $display("FAIL single_fv_rise: got %b want 1", pix_fv); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy: got %b want 1", busy); end
    wait_idle(300, ok);
    checks++; if (!ok) begin failures++; $display("FAIL single_timeout: busy %b want 0", busy); end
    exp_fc = exp_fc + 16'd1;
    checks++; if (frame_count !== exp_fc) begin failures++; $display("FAIL single_fc: got %h want %h", frame_count, exp_fc); end
    checks++; if (obs_hi.size() != 1 || obs_hi[0] != 48) begin failures++; $display("FAIL single_fv_len: got %0d (n=%0d) want 48", (obs_hi.size() > 0) ? obs_hi[0] : -1, obs_hi.size()); end
    checks++; if (obs_burst.size() != 3) begin failures++; $display("FAIL single_bursts: got %0d want 3", obs_burst.size()); end
    for (int i = 0; i < obs_burst.size(); i++) begin
      checks++; if (obs_burst[i] != 8) begin failures++; $display("FAIL single_burst_len: got %0d want 8", obs_burst[i]); end
    end
    checks++; if (obs_gap.size() != 2) begin failures++; $display("FAIL single_gaps: got %0d want 2", obs_gap.size()); end
    for (int i = 0; i < obs_gap.size(); i++) begin
      checks++; if (obs_gap[i] != 4) begin failures++; $display("FAIL single_gap_len: got %0d want 4", obs_gap[i]); end
    end
    checks++; if (obs_lead.size() != 1 || obs_lead[0] != 8) begin failures++; $display("FAIL single_lead: got %0d want 8", (obs_lead.size() > 0) ? obs_lead[0] : -1); end
    checks++; if (obs_trail.size() != 1 || obs_trail[0] != 8) begin failures++; $display("FAIL single_trail: got %0d want 8", (obs_trail.size() > 0) ? obs_trail[0] : -1); end
    while (exp_pix.size() > 0) begin
      e = exp_pix.pop_front();
      checks++;
      if (obs_pix.size() == 0) begin failures++; $display("FAIL single_pix: missing, want %h", e); end
      else begin
        o = obs_pix.pop_front();
        if (o !== e) begin failures++; $display("FAIL single_pix: got %h want %h", o, e); end
      end
    end
    checks++; if (obs_pix.size() != 0) begin failures++; $display("FAIL single_extra_pix: got %0d want 0", obs_pix.size()); end
    fv_seen = 0;
    repeat (15) begin @(negedge clk); if (pix_fv !== 1'b0) fv_seen++; end
    checks++; if (fv_seen != 0) begin failures++; $display("FAIL single_stays_idle: fv cycles %0d want 0", fv_seen); end
    checks++; if (proto_viol != viol0) begin failures++; $display("FAIL single_protocol: got %0d want %0d", proto_viol, viol0); end
  endtask

  task automatic test_checker();
    bit ok;
    int viol0;
    logic [11:0] e, o;
    clear_obs();
    viol0 = proto_viol;
    set_cfg(2'd2, 12'd16, 12'd4, 12'd16, 16'd10);
    push_frame(2, 16, 16, int'(exp_fc));
    push_frame(2, 16, 16, int'(exp_fc) + 1);
    @(negedge clk); enable = 1'b1;
    wait_fv_rises(2, 1000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL checker_second_frame: fv %b want 1", pix_fv); end
    repeat (50) @(negedge clk);
    enable = 1'b0;
    wait_idle(1000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL checker_timeout: busy %b want 0", busy); end
    exp_fc = exp_fc + 16'd2;
    checks++; if (frame_count !== exp_fc) begin failures++; $display("FAIL checker_fc: got %h want %h", frame_count, exp_fc); end
    checks++; if (obs_hi.size() != 2) begin failures++; $display("FAIL checker_frames: got %0d want 2", obs_hi.size()); end
    for (int i = 0; i < obs_hi.size(); i++) begin
      checks++; if (obs_hi[i] != 332) begin failures++; $display("FAIL checker_fv_len: got %0d want 332", obs_hi[i]); end
    end
    checks++; if (obs_lo.size() < 2 || obs_lo[obs_lo.size() - 1] != 10) begin failures++; $display("FAIL checker_fv_low: got %0d want 10", (obs_lo.size() > 0) ? obs_lo[obs_lo.size() - 1] : -1); end
    while (exp_pix.size() > 0) begin
      e = exp_pix.pop_front();
      checks++;
      if (obs_pix.size() == 0) begin failures++; $display("FAIL checker_pix: missing, want %h", e); end
      else begin
        o = obs_pix.pop_front();
        if (o !== e) begin failures++; $display("FAIL checker_pix: got %h want %h", o, e); end
      end
    end
    checks++; if (proto_viol != viol0) begin failures++; $display("FAIL checker_protocol: got %0d want %0d", proto_viol, viol0); end
  endtask

  task automatic test_mid_change();
    bit ok;
    int exp_b[4] = '{8, 8, 20, 20};
    logic [11:0] e, o;
    clear_obs();
    set_cfg(2'd0, 12'd8, 12'd2, 12'd2, 16'd3);
    push_frame(0, 8, 2, int'(exp_fc));
    push_frame(0, 20, 2, int'(exp_fc) + 1);
    @(negedge clk); enable = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin @(negedge clk); if (pix_lv) begin ok = 1'b1; break; end end
    checks++; if (!ok) begin failures++; $display("FAIL change_lv_start: lv %b want 1", pix_lv); end
    h_active = 12'd20;
    wait_fv_rises(1, 200, ok);
    checks++; if (!ok) begin failures++; $display("FAIL change_next_frame: fv %b want 1", pix_fv); end
    enable = 1'b0;
    wait_idle(300, ok);
    checks++; if (!ok) begin failures++; $display("FAIL change_timeout: busy %b want 0", busy); end
    exp_fc = exp_fc + 16'd2;
    checks++; if (frame_count !== exp_fc) begin failures++; $display("FAIL change_fc: got %h want %h", frame_count, exp_fc); end
    checks++; if (obs_burst.size() != 4) begin failures++; $display("FAIL change_bursts: got %0d want 4", obs_burst.size()); end
    for (int i = 0; i < 4 && i < obs_burst.size(); i++) begin
      checks++; if (obs_burst[i] != exp_b[i]) begin failures++; $display("FAIL change_burst_len: line %0d got %0d want %0d", i, obs_burst[i], exp_b[i]); end
    end
    while (exp_pix.size() > 0) begin
      e = exp_pix.pop_front();
      checks++;
      if (obs_pix.size() == 0) begin failures++; $display("FAIL change_pix: missing, want %h", e); end
      else begin
        o = obs_pix.pop_front();
        if (o !== e) begin failures++; $display("FAIL change_pix: got %h want %h", o, e); end
      end
    end
  endtask

  task automatic test_zero_cfg();
    bit ok;
    logic [11:0] e, o;
    clear_obs();
    set_cfg(2'd0, 12'd0, 12'd0, 12'd0, 16'd0);
    push_frame(0, 0, 0, int'(exp_fc));
    push_frame(0, 0, 0, int'(exp_fc) + 1);
    @(negedge clk); enable = 1'b1;
    wait_fv_rises(2, 200, ok);
    checks++; if (!ok) begin failures++; $display("FAIL zero_second_frame: fv %b want 1", pix_fv); end
    enable = 1'b0;
    wait_idle(200, ok);
    checks++; if (!ok) begin failures++; $display("FAIL zero_timeout: busy %b want 0", busy); end
    exp_fc = exp_fc + 16'd2;
    checks++; if (frame_count !== exp_fc) begin failures++; $display("FAIL zero_fc: got %h want %h", frame_count, exp_fc); end
    checks++; if (obs_hi.size() != 2) begin failures++; $display("FAIL zero_frames: got %0d want 2", obs_hi.size()); end
    for (int i = 0; i < obs_hi.size(); i++) begin
      checks++; if (obs_hi[i] != 17) begin failures++; $display("FAIL zero_fv_len: got %0d want 17", obs_hi[i]); end
    end
    checks++; if (obs_lo.size() < 2 || obs_lo[obs_lo.size() - 1] != 1) begin failures++; $display("FAIL zero_fv_low: got %0d want 1", (obs_lo.size() > 0) ? obs_lo[obs_lo.size() - 1] : -1); end
    checks++; if (obs_burst.size() != 2 || obs_burst[0] != 1 || obs_burst[1] != 1) begin failures++; $display("FAIL zero_bursts: got n=%0d first=%0d want 2 bursts of 1", obs_burst.size(), (obs_burst.size() > 0) ? obs_burst[0] : -1); end
    while (exp_pix.size() > 0) begin
      e = exp_pix.pop_front();
      checks++;
      if (obs_pix.size() == 0) begin failures++; $display("FAIL zero_pix: missing, want %h", e); end
      else begin
        o = obs_pix.pop_front();
        if (o !== e) begin failures++; $display("FAIL zero_pix: got %h want %h", o, e); end
      end
    end
  endtask

  task automatic test_reset_mid_line();
    bit ok;
    int fv_seen;
    clear_obs();
    set_cfg(2'd0, 12'd16, 12'd4, 12'd4, 16'd10);
    @(negedge clk); enable = 1'b1;
    @(negedge clk); enable = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (pix_lv && pix_data == 12'd5) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin failures++; $display("FAIL rst_line_reached: lv %b data %h want 1 / 005", pix_lv, pix_data); end
    #2 reset = 1'b1;
    #1;
    checks++; if (pix_fv !== 1'b0) begin failures++; $display("FAIL rst_async_fv: got %b want 0", pix_fv); end
    checks++; if (pix_lv !== 1'b0) begin failures++; $display("FAIL rst_async_lv: got %b want 0", pix_lv); end
    checks++; if (pix_data !== 12'd0) begin failures++; $display("FAIL rst_async_data: got %h want 000", pix_data); end
    checks++; if (frame_count !== 16'd0) begin failures++; $display("FAIL rst_async_fc: got %h want 0000", frame_count); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_async_busy: got %b want 0", busy); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_fc = 16'd0;
    fv_seen = 0;
    repeat (30) begin @(negedge clk); if (pix_fv !== 1'b0) fv_seen++; end
    checks++; if (fv_seen != 0) begin failures++; $display("FAIL rst_no_restart: fv cycles %0d want 0", fv_seen); end
    clear_obs();
  endtask

  task automatic test_wrap();
    bit ok;
    logic [11:0] e, o;
    clear_obs();
    set_cfg(2'd3, 12'd4, 12'd1, 12'd2, 16'd2);
    @(negedge clk);
    force dut.frame_cnt_r = 16'hFFFE;
    @(negedge clk);
    release dut.frame_cnt_r;
    @(negedge clk);
    exp_fc = 16'hFFFE;
    checks++; if (frame_count !== exp_fc) begin failures++; $display("FAIL wrap_preload: got %h want %h", frame_count, exp_fc); end
    push_frame(3, 4, 2, 16'hFFFE);
    push_frame(3, 4, 2, 16'hFFFF);
    push_frame(3, 4, 2, 0);
    enable = 1'b1;
    wait_fv_rises(3, 300, ok);
    checks++; if (!ok) begin failures++; $display("FAIL wrap_third_frame: fv %b want 1", pix_fv); end
    checks++; if (frame_count !== 16'h0000) begin failures++; $display("FAIL wrap_to_zero: got %h want 0000", frame_count); end
    enable = 1'b0;
    wait_idle(300, ok);
    checks++; if (!ok) begin failures++; $display("FAIL wrap_timeout: busy %b want 0", busy); end
    exp_fc = exp_fc + 16'd3;
    checks++; if (frame_count !== exp_fc) begin failures++; $display("FAIL wrap_fc: got %h want %h", frame_count, exp_fc); end
    while (exp_pix.size() > 0) begin
      e = exp_pix.pop_front();
      checks++;
      if (obs_pix.size() == 0) begin failures++; $display("FAIL wrap_pix: missing, want %h", e); end
      else begin
        o = obs_pix.pop_front();
        if (o !== e) begin failures++; $display("FAIL wrap_pix: got %h want %h", o, e); end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_frame();
    test_checker();
    test_mid_change();
    test_zero_cfg();
    test_reset_mid_line();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
